// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: decoder codes, FSM states,
// the decoded access descriptor and small decode helpers.
package lsu_pkg;

  localparam logic [2:0] MEMREAD_NONE = 3'd0;
  localparam logic [2:0] MEMREAD_LB   = 3'd1;
  localparam logic [2:0] MEMREAD_LH   = 3'd2;
  localparam logic [2:0] MEMREAD_LW   = 3'd3;
  localparam logic [2:0] MEMREAD_LBU  = 3'd4;
  localparam logic [2:0] MEMREAD_LHU  = 3'd5;

  localparam logic [1:0] MEMWRITE_NONE = 2'd0;
  localparam logic [1:0] MEMWRITE_SB   = 2'd1;
  localparam logic [1:0] MEMWRITE_SH   = 2'd2;
  localparam logic [1:0] MEMWRITE_SW   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef struct packed {
    logic  store;
    size_t size;
    logic  uns;
  } op_t;

  // A store code always takes priority over any simultaneous load code.
  function automatic op_t decode_op(input logic [2:0] mem_read, input logic [1:0] mem_write);
    op_t op;
    op = '{store: 1'b0, size: SZ_WORD, uns: 1'b0};
    if (mem_write != MEMWRITE_NONE) begin
      op.store = 1'b1;
      case (mem_write)
        MEMWRITE_SB: op.size = SZ_BYTE;
        MEMWRITE_SH: op.size = SZ_HALF;
        default:     op.size = SZ_WORD;
      endcase
    end else begin
      case (mem_read)
        MEMREAD_LB:  op.size = SZ_BYTE;
        MEMREAD_LH:  op.size = SZ_HALF;
        MEMREAD_LBU: begin op.size = SZ_BYTE; op.uns = 1'b1; end
        MEMREAD_LHU: begin op.size = SZ_HALF; op.uns = 1'b1; end
        default:     op.size = SZ_WORD;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_access(input logic [2:0] mem_read, input logic [1:0] mem_write);
    return (mem_write != MEMWRITE_NONE) ||
           ((mem_read >= MEMREAD_LB) && (mem_read <= MEMREAD_LHU));
  endfunction

  function automatic logic is_misaligned(input size_t size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store-data replication on the
// way out, lane selection and sign/zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
(
  input  op_t         i_op,
  input  logic [1:0]  i_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Outbound byte enables and replicated store data.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0000_0000;
    case (i_op.size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SZ_WORD: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = 32'h0000_0000;
      end
    endcase
    if (!i_op.store) begin
      o_wdata = 32'h0000_0000;
    end else begin
      o_wdata = o_wdata;
    end
  end

  // Inbound lane select and extension.
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    o_load = 32'h0000_0000;
    case (i_lo)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      2'd3:    w_byte = i_mem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (i_op.size)
      SZ_BYTE: o_load = i_op.uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_load = i_op.uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      SZ_WORD: o_load = i_mem_rdata;
      default: o_load = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE/REQ/RESP handshake FSM with wait counter, timeout
// and misalignment detection between the core and the data-memory bus.
module lsu
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MAX_WAIT) + 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t         r_state, w_next_state;
  op_t            r_op;
  logic [1:0]     r_lo;
  logic [CW-1:0]  r_wait;
  logic           r_done, r_misalign, r_bus_err;
  logic [31:0]    r_rdata;
  logic           r_mem_req, r_mem_we;
  logic [31:0]    r_mem_addr, r_mem_wdata;
  logic [3:0]     r_mem_be;

  op_t            w_op_in, w_align_op;
  logic           w_access, w_misal, w_timeout;
  logic [1:0]     w_align_lo;
  logic [3:0]     w_be;
  logic [31:0]    w_wdata_rep, w_load;

  assign w_op_in   = decode_op(MemRead, MemWrite);
  assign w_access  = is_access(MemRead, MemWrite);
  assign w_misal   = is_misaligned(w_op_in.size, addr[1:0]);
  assign w_timeout = (r_wait == LAST_WAIT);

  // Lane logic sees the live instruction in IDLE and the latched one afterwards.
  assign w_align_op = (r_state == ST_IDLE) ? w_op_in : r_op;
  assign w_align_lo = (r_state == ST_IDLE) ? addr[1:0] : r_lo;

  lsu_align u_align (
    .i_op        (w_align_op),
    .i_lo        (w_align_lo),
    .i_wdata     (wdata),
    .i_mem_rdata (mem_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata_rep),
    .o_load      (w_load)
  );

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_next_state = w_misal ? ST_RESP : ST_REQ;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack || w_timeout) begin
          w_next_state = ST_RESP;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, latched access, bus drive registers and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= '{store: 1'b0, size: SZ_WORD, uns: 1'b0};
      r_lo        <= 2'b00;
      r_wait      <= '0;
      r_done      <= 1'b0;
      r_misalign  <= 1'b0;
      r_bus_err   <= 1'b0;
      r_rdata     <= 32'h0000_0000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0000_0000;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_access && !w_misal) begin
            r_op        <= w_op_in;
            r_lo        <= addr[1:0];
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_op_in.store;
            r_mem_addr  <= {addr[31:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata_rep;
          end else if (w_access) begin
            r_done     <= 1'b1;
            r_misalign <= 1'b1;
            r_rdata    <= 32'h0000_0000;
          end
        end
        ST_REQ: begin
          r_wait <= r_wait + CW'(1);
          // An ack in the timeout cycle still completes normally.
          if (mem_ack || w_timeout) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0000_0000;
            r_mem_be    <= 4'b0000;
            r_mem_wdata <= 32'h0000_0000;
            r_done      <= 1'b1;
            r_bus_err   <= !mem_ack;
            r_rdata     <= (mem_ack && !r_op.store) ? w_load : 32'h0000_0000;
          end
        end
        ST_RESP: begin
          r_wait     <= '0;
          r_done     <= 1'b0;
          r_misalign <= 1'b0;
          r_bus_err  <= 1'b0;
          r_rdata    <= 32'h0000_0000;
        end
        default: begin
          r_wait    <= '0;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = rst_n && (((r_state == ST_IDLE) && w_access) || (r_state == ST_REQ));
  assign rdata     = r_rdata;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: hand-computed expectations checked with immediate
// assertions, all sampling one time unit after the falling clock edge.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  MemRead = 3'd0;
  logic [1:0]  MemWrite = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall, done, misalign, bus_err, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;
  int stall_cnt;
  int req_cnt;
  int req_seen;

  lsu #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
    .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;

    // Reset state, with an access code already present.
    MemRead = 3'd3;
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    MemRead = 3'd0;
    step();
    rst_n = 1'b1;
    step();

    // LB at 0x1003, zero-wait.
    MemRead = 3'd1; addr = 32'h0000_1003;
    #1;
    check("lb_stall0", {31'd0, stall}, 32'd1);
    step();
    MemRead = 3'd0;
    check("lb_req", {31'd0, mem_req}, 32'd1);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    step();
    mem_ack = 1'b0;
    check("lb_done", {31'd0, done}, 32'd1);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    check("lb_stall2", {31'd0, stall}, 32'd0);
    step();
    check("lb_nodone", {31'd0, done}, 32'd0);

    // LBU, same stimulus.
    MemRead = 3'd4; addr = 32'h0000_1003;
    step();
    MemRead = 3'd0;
    mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
    step();
    mem_ack = 1'b0;
    check("lbu_done", {31'd0, done}, 32'd1);
    check("lbu_rdata", rdata, 32'h0000_0080);
    step();

    // LHU at 0x2002 with three wait cycles.
    MemRead = 3'd5; addr = 32'h0000_2002; mem_rdata = 32'hBEEF_1234;
    #1;
    stall_cnt = stall ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      step();
      MemRead = 3'd0;
      if (stall) stall_cnt++;
      if (i == 3) mem_ack = 1'b1;
    end
    step();
    mem_ack = 1'b0;
    if (stall) stall_cnt++;
    check("lhu_done", {31'd0, done}, 32'd1);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    check("lhu_stall_cycles", stall_cnt, 32'd5);
    step();

    // SH at 0x3002, bus fields held through two waits.
    MemWrite = 2'd2; MemRead = 3'd1; addr = 32'h0000_3002; wdata = 32'h1234_ABCD;
    for (int i = 0; i < 3; i++) begin
      step();
      MemWrite = 2'd0; MemRead = 3'd0; wdata = 32'h0;
      check("sh_req", {31'd0, mem_req}, 32'd1);
      check("sh_addr", mem_addr, 32'h0000_3000);
      check("sh_be", {28'd0, mem_be}, 32'h0000_000C);
      check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
      check("sh_we", {31'd0, mem_we}, 32'd1);
      if (i == 2) mem_ack = 1'b1;
    end
    step();
    mem_ack = 1'b0;
    check("sh_done", {31'd0, done}, 32'd1);
    check("sh_rdata", rdata, 32'h0);
    step();

    // Misaligned LW at 0x4001.
    MemRead = 3'd3; addr = 32'h0000_4001; mem_ack = 1'b1;
    #1;
    check("mis_stall", {31'd0, stall}, 32'd1);
    step();
    MemRead = 3'd0;
    check("mis_done", {31'd0, done}, 32'd1);
    check("mis_flag", {31'd0, misalign}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_rdata", rdata, 32'h0);
    check("mis_stall1", {31'd0, stall}, 32'd0);
    step();
    mem_ack = 1'b0;
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_req2", {31'd0, mem_req}, 32'd0);

    // Timeout: LW with no ack.
    MemRead = 3'd3; addr = 32'h0000_5000;
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      MemRead = 3'd0;
      if (done) break;
      if (mem_req) req_cnt++;
    end
    check("to_req_cycles", req_cnt, 32'd16);
    check("to_done", {31'd0, done}, 32'd1);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    check("to_rdata", rdata, 32'h0);
    step();

    // Ack in the 16th REQ cycle wins over the timeout.
    MemRead = 3'd3; addr = 32'h0000_5000; mem_rdata = 32'hCAFE_F00D;
    req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      MemRead = 3'd0;
      mem_ack = 1'b0;
      if (done) break;
      if (mem_req) req_cnt++;
      if (req_cnt == 16) mem_ack = 1'b1;
    end
    check("late_ack_cycles", req_cnt, 32'd16);
    check("late_ack_done", {31'd0, done}, 32'd1);
    check("late_ack_no_err", {31'd0, bus_err}, 32'd0);
    check("late_ack_rdata", rdata, 32'hCAFE_F00D);
    step();

    // Reset in the middle of a store request.
    MemWrite = 2'd3; addr = 32'h0000_6000; wdata = 32'h5555_AAAA;
    step();
    check("rr_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_req_drop", {31'd0, mem_req}, 32'd0);
    check("rr_stall", {31'd0, stall}, 32'd0);
    check("rr_be", {28'd0, mem_be}, 32'h0);
    check("rr_wdata", mem_wdata, 32'h0);
    step();
    MemWrite = 2'd0;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done || mem_req) req_seen++;
    end
    mem_ack = 1'b0;
    check("rr_no_done", req_seen, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
